// File: rtl/alarm_rtc_counter_if.sv
// alarm_rtc_counter_if: 16-bit Avalon-MM slave bus plus alarm interrupt line
interface alarm_rtc_counter_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
endinterface

// File: rtl/alarm_rtc_counter.sv
// alarm_rtc_counter: HH:MM:SS time-of-day counter with alarm compare and Avalon-MM register access
module alarm_rtc_counter #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int PRESCALE_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick_in,
    alarm_rtc_counter_if.slave bus
);
    logic [5:0]            r_sec, r_min, r_alarm_min;
    logic [4:0]            r_hour, r_alarm_hour;
    logic [2:0]            r_ctrl;
    logic                  r_alarm_occ;
    logic [PRESCALE_W-1:0] r_pre;
    logic [15:0]           r_rdata;
    logic                  w_wr, w_wr_status, w_wr_ctrl, w_wr_sec, w_wr_min, w_wr_hour;
    logic                  w_wr_amin, w_wr_ahour, w_wr_time;
    logic                  w_tick, w_pre_last, w_sec_adv, w_sec_carry, w_min_carry, w_alarm_evt;
    logic [5:0]            w_sec_nxt, w_min_nxt, w_wdata6;
    logic [4:0]            w_hour_nxt, w_wdata5;
    logic [15:0]           w_rmux;

    assign w_wr        = bus.chipselect && !bus.write_n;
    assign w_wr_status = w_wr && bus.address == 3'd0;
    assign w_wr_ctrl   = w_wr && bus.address == 3'd1;
    assign w_wr_sec    = w_wr && bus.address == 3'd2;
    assign w_wr_min    = w_wr && bus.address == 3'd3;
    assign w_wr_hour   = w_wr && bus.address == 3'd4;
    assign w_wr_amin   = w_wr && bus.address == 3'd5;
    assign w_wr_ahour  = w_wr && bus.address == 3'd6;
    assign w_wr_time   = w_wr_sec || w_wr_min || w_wr_hour;

    assign w_tick      = r_ctrl[0] && tick_in;
    assign w_pre_last  = r_pre == PRESCALE_W'(TICKS_PER_SEC - 1);
    assign w_sec_adv   = w_tick && w_pre_last;
    assign w_sec_carry = w_sec_adv && r_sec == 6'd59;
    assign w_min_carry = w_sec_carry && r_min == 6'd59;
    assign w_sec_nxt   = w_sec_carry ? 6'd0 : r_sec + 6'(w_sec_adv);
    assign w_min_nxt   = w_min_carry ? 6'd0 : r_min + 6'(w_sec_carry);
    assign w_hour_nxt  = (w_min_carry && r_hour == 5'd23) ? 5'd0 : r_hour + 5'(w_min_carry);

    // Out-of-range field writes collapse to zero after masking to the field width
    assign w_wdata6 = bus.writedata[5:0] > 6'd59 ? 6'd0 : bus.writedata[5:0];
    assign w_wdata5 = bus.writedata[4:0] > 5'd23 ? 5'd0 : bus.writedata[4:0];

    // Only a counted second can raise the alarm; software time writes never do
    assign w_alarm_evt = w_sec_adv && !w_wr_time && r_ctrl[2] && w_sec_nxt == 6'd0 &&
                         w_min_nxt == r_alarm_min && w_hour_nxt == r_alarm_hour;

    always_comb begin
        w_rmux = '0;
        case (bus.address)
            3'd0:    w_rmux = {14'd0, r_ctrl[0], r_alarm_occ};
            3'd1:    w_rmux = {13'd0, r_ctrl};
            3'd2:    w_rmux = {10'd0, r_sec};
            3'd3:    w_rmux = {10'd0, r_min};
            3'd4:    w_rmux = {11'd0, r_hour};
            3'd5:    w_rmux = {10'd0, r_alarm_min};
            3'd6:    w_rmux = {11'd0, r_alarm_hour};
            default: w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sec        <= '0;
            r_min        <= '0;
            r_hour       <= '0;
            r_alarm_min  <= '0;
            r_alarm_hour <= '0;
            r_ctrl       <= '0;
            r_alarm_occ  <= 1'b0;
            r_pre        <= '0;
            r_rdata      <= '0;
        end else begin
            r_pre        <= w_wr_time ? '0 : w_tick ? (w_pre_last ? '0 : r_pre + PRESCALE_W'(1)) : r_pre;
            r_sec        <= w_wr_sec ? w_wdata6 : w_sec_nxt;
            r_min        <= w_wr_min ? w_wdata6 : w_min_nxt;
            r_hour       <= w_wr_hour ? w_wdata5 : w_hour_nxt;
            r_alarm_min  <= w_wr_amin ? w_wdata6 : r_alarm_min;
            r_alarm_hour <= w_wr_ahour ? w_wdata5 : r_alarm_hour;
            r_ctrl       <= w_wr_ctrl ? bus.writedata[2:0] : r_ctrl;
            r_alarm_occ  <= w_alarm_evt || (r_alarm_occ && !w_wr_status);
            r_rdata      <= w_rmux;
        end
    end

    assign bus.readdata = r_rdata;
    assign bus.irq      = r_alarm_occ && r_ctrl[1];
endmodule

// File: tb/tb_alarm_rtc_counter.sv
// tb_alarm_rtc_counter: directed register-level checks of the RTC with a 4-tick second
module tb_alarm_rtc_counter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick_in = 1'b0;
    logic [15:0] rd;
    int          checks = 0;
    int          errors = 0;

    alarm_rtc_counter_if bus();

    alarm_rtc_counter #(.TICKS_PER_SEC(4), .PRESCALE_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick_in = 1'b1;
            @(negedge clk);
            tick_in = 1'b0;
        end
    endtask

    task automatic set_time(input logic [15:0] h, input logic [15:0] m, input logic [15:0] s);
        wr(3'd4, h); wr(3'd3, m); wr(3'd2, s);
    endtask

    initial begin
        bus.address = '0; bus.writedata = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reach 12:34:56 with alarm_occurred set and prescaler mid-count
        set_time(16'd12, 16'd33, 16'd59);
        wr(3'd5, 16'd34); wr(3'd6, 16'd12);
        wr(3'd1, 16'h7);
        ticks(4);
        check("pre_reset_irq", {15'd0, bus.irq}, 16'd1);
        wr(3'd2, 16'd56);
        ticks(2);
        rd_reg(3'd2, rd); check("pre_reset_sec", rd, 16'd56);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        check("reset_irq", {15'd0, bus.irq}, 16'd0);
        check("reset_rdata", bus.readdata, 16'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a), rd); check($sformatf("reset_reg%0d", a), rd, 16'd0);
        end

        // Counting, prescaler cleared by reset
        wr(3'd1, 16'h1);
        ticks(3);
        rd_reg(3'd2, rd); check("cnt_3ticks", rd, 16'd0);
        ticks(1);
        rd_reg(3'd2, rd); check("cnt_4ticks", rd, 16'd1);
        rd_reg(3'd0, rd); check("status_running", rd, 16'd2);
        ticks(2);
        wr(3'd1, 16'h0);
        ticks(5);
        rd_reg(3'd2, rd); check("paused_sec", rd, 16'd1);
        rd_reg(3'd0, rd); check("status_stopped", rd, 16'd0);
        wr(3'd1, 16'h1);
        ticks(2);
        rd_reg(3'd2, rd); check("resume_sec", rd, 16'd2);

        // Full-day wrap
        wr(3'd1, 16'h0);
        set_time(16'd23, 16'd59, 16'd59);
        wr(3'd1, 16'h1);
        ticks(4);
        rd_reg(3'd4, rd); check("wrap_hour", rd, 16'd0);
        rd_reg(3'd3, rd); check("wrap_min", rd, 16'd0);
        rd_reg(3'd2, rd); check("wrap_sec", rd, 16'd0);

        // Alarm at 07:00
        wr(3'd1, 16'h0);
        wr(3'd5, 16'd0); wr(3'd6, 16'd7);
        set_time(16'd6, 16'd59, 16'd59);
        wr(3'd1, 16'h7);
        ticks(3);
        check("alarm_early_irq", {15'd0, bus.irq}, 16'd0);
        ticks(1);
        check("alarm_irq", {15'd0, bus.irq}, 16'd1);
        rd_reg(3'd0, rd); check("alarm_status", rd, 16'd3);
        rd_reg(3'd4, rd); check("alarm_hour", rd, 16'd7);
        wr(3'd0, 16'h0);
        check("clear_irq", {15'd0, bus.irq}, 16'd0);
        rd_reg(3'd0, rd); check("clear_status", rd, 16'd2);

        // alarm_en off
        wr(3'd1, 16'h0);
        set_time(16'd6, 16'd59, 16'd59);
        wr(3'd1, 16'h3);
        ticks(4);
        check("noen_irq", {15'd0, bus.irq}, 16'd0);
        rd_reg(3'd0, rd); check("noen_status", rd, 16'd2);

        // STATUS write coinciding with the alarm event
        wr(3'd1, 16'h0);
        set_time(16'd6, 16'd59, 16'd59);
        wr(3'd1, 16'h7);
        ticks(3);
        @(negedge clk);
        tick_in = 1'b1;
        bus.address = 3'd0; bus.writedata = 16'h0; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        tick_in = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        check("simul_irq", {15'd0, bus.irq}, 16'd1);
        rd_reg(3'd0, rd); check("simul_status", rd, 16'd3);
        wr(3'd0, 16'h0);

        // SEC write coinciding with sec_adv
        wr(3'd1, 16'h0);
        set_time(16'd1, 16'd2, 16'd20);
        wr(3'd1, 16'h1);
        ticks(3);
        @(negedge clk);
        tick_in = 1'b1;
        bus.address = 3'd2; bus.writedata = 16'd10; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        tick_in = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        rd_reg(3'd2, rd); check("wr_adv_sec", rd, 16'd10);
        ticks(3);
        rd_reg(3'd2, rd); check("wr_adv_pre_cleared", rd, 16'd10);
        ticks(1);
        rd_reg(3'd2, rd); check("wr_adv_next", rd, 16'd11);

        // Bus range, masking and latency
        wr(3'd1, 16'h0);
        wr(3'd2, 16'd60);   rd_reg(3'd2, rd); check("sec_60", rd, 16'd0);
        wr(3'd2, 16'h3F);   rd_reg(3'd2, rd); check("sec_63", rd, 16'd0);
        wr(3'd3, 16'hFF3B); rd_reg(3'd3, rd); check("min_masked", rd, 16'd59);
        wr(3'd4, 16'h1F);   rd_reg(3'd4, rd); check("hour_1f", rd, 16'd0);
        wr(3'd4, 16'd24);   rd_reg(3'd4, rd); check("hour_24", rd, 16'd0);
        wr(3'd6, 16'd23);   rd_reg(3'd6, rd); check("ahour_23", rd, 16'd23);
        wr(3'd5, 16'd61);   rd_reg(3'd5, rd); check("amin_61", rd, 16'd0);
        wr(3'd1, 16'hFFFE); rd_reg(3'd1, rd); check("ctrl_masked", rd, 16'd6);
        wr(3'd7, 16'hFFFF); rd_reg(3'd7, rd); check("addr7", rd, 16'd0);
        rd_reg(3'd1, rd); check("addr7_no_effect", rd, 16'd6);
        wr(3'd3, 16'd42);
        @(negedge clk); bus.address = 3'd1;
        @(negedge clk); bus.address = 3'd3; check("lat_ctrl", bus.readdata, 16'd6);
        @(negedge clk); check("lat_min", bus.readdata, 16'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
